// File: rtl/ex_mem_stage.sv
// ============================================================================
// Module      : ex_mem_stage
// Description : Execute-to-memory pipeline register with a 2-entry skid buffer
//               (registered in_ready), flush support and x0 write suppression.
//               Optional macro EX_MEM_STALL_CNT_EN adds a stall cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_stage #(
    parameter int N          = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          in_z,
    input  logic                  in_equal,
    input  logic                  in_zero,
    input  logic [N-1:0]          in_store_data,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_we,
    input  logic [CTRL_W-1:0]     in_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N-1:0]          out_z,
    output logic                  out_equal,
    output logic                  out_zero,
    output logic [N-1:0]          out_store_data,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_we,
`ifdef EX_MEM_STALL_CNT_EN
    output logic [31:0]           stall_cycles,
`endif
    output logic [CTRL_W-1:0]     out_ctrl
);

    typedef struct packed {
        logic [N-1:0]          z;
        logic                  equal;
        logic                  zero;
        logic [N-1:0]          store_data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_we;
        logic [CTRL_W-1:0]     ctrl;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    entry_t r_main;
    entry_t r_skid;
    entry_t w_entry_in;
    logic   r_out_valid;
    logic   r_in_ready;
    logic   w_accept;
    logic   w_pop;
    logic   w_main_ld_in;
    logic   w_main_ld_skid;
    logic   w_skid_ld;

    // Register x0 is hardwired zero, so a write to it is never requested downstream.
    always_comb begin
        w_entry_in            = '0;
        w_entry_in.z          = in_z;
        w_entry_in.equal      = in_equal;
        w_entry_in.zero       = in_zero;
        w_entry_in.store_data = in_store_data;
        w_entry_in.rd         = in_rd;
        w_entry_in.reg_we     = in_reg_we & (in_rd != '0);
        w_entry_in.ctrl       = in_ctrl;
    end

    assign w_accept = in_valid & r_in_ready & ~flush;
    assign w_pop    = r_out_valid & out_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_main_ld_in   = 1'b0;
        w_main_ld_skid = 1'b0;
        w_skid_ld      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt  = ST_ONE;
                        w_main_ld_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        w_main_ld_in = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = ST_TWO;
                        w_skid_ld   = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        w_state_nxt    = ST_ONE;
                        w_main_ld_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Valid and ready are derived from the next state so both leave flops directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_in_ready  <= (w_state_nxt != ST_TWO);
            if (w_main_ld_in) begin
                r_main <= w_entry_in;
            end else if (w_main_ld_skid) begin
                r_main <= r_skid;
            end
            if (w_skid_ld) begin
                r_skid <= w_entry_in;
            end
        end
    end

`ifdef EX_MEM_STALL_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (r_out_valid && !out_ready) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

    assign in_ready       = r_in_ready;
    assign out_valid      = r_out_valid;
    assign out_z          = r_main.z;
    assign out_equal      = r_main.equal;
    assign out_zero       = r_main.zero;
    assign out_store_data = r_main.store_data;
    assign out_rd         = r_main.rd;
    assign out_reg_we     = r_main.reg_we;
    assign out_ctrl       = r_main.ctrl;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// ============================================================================
// Module      : tb_ex_mem_stage
// Description : Scoreboard bench for ex_mem_stage; directed stimulus with an
//               expected-entry queue drained by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_z = '0;
    logic        in_equal = 1'b0;
    logic        in_zero = 1'b0;
    logic [31:0] in_store_data = '0;
    logic [4:0]  in_rd = '0;
    logic        in_reg_we = 1'b0;
    logic [5:0]  in_ctrl = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_z;
    logic        out_equal;
    logic        out_zero;
    logic [31:0] out_store_data;
    logic [4:0]  out_rd;
    logic        out_reg_we;
    logic [5:0]  out_ctrl;
`ifdef EX_MEM_STALL_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] exp_stall = '0;
`endif

    ex_mem_stage #(.N(32), .REG_ADDR_W(5), .CTRL_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_z           (in_z),
        .in_equal       (in_equal),
        .in_zero        (in_zero),
        .in_store_data  (in_store_data),
        .in_rd          (in_rd),
        .in_reg_we      (in_reg_we),
        .in_ctrl        (in_ctrl),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_z          (out_z),
        .out_equal      (out_equal),
        .out_zero       (out_zero),
        .out_store_data (out_store_data),
        .out_rd         (out_rd),
        .out_reg_we     (out_reg_we),
`ifdef EX_MEM_STALL_CNT_EN
        .stall_cycles   (stall_cycles),
`endif
        .out_ctrl       (out_ctrl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] z;
        logic        eq;
        logic        zr;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        we;
        logic [5:0]  ctrl;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [31:0] z, input logic [4:0] rd,
                        input logic we, input logic ordy, input logic fl, input logic rs);
        logic rdy;
        exp_t e;
        in_valid      = v;
        in_z          = z;
        in_rd         = rd;
        in_reg_we     = we;
        in_store_data = z ^ 32'hFFFF_0000;
        in_ctrl       = z[5:0];
        in_equal      = z[0];
        in_zero       = (z == 32'd0);
        out_ready     = ordy;
        flush         = fl;
        rst           = rs;
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        #1;
        if (rs || fl) begin
            q.delete();
        end else if (v && rdy) begin
            e.z    = z;
            e.eq   = z[0];
            e.zr   = (z == 32'd0);
            e.sd   = z ^ 32'hFFFF_0000;
            e.rd   = rd;
            e.we   = we && (rd != 5'd0);
            e.ctrl = z[5:0];
            q.push_back(e);
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, 5'd0, 1'b0, ordy, 1'b0, 1'b0);
    endtask

    // Monitor: occupancy, presented entry and pop, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
            check("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
            if (out_valid && q.size() > 0) begin
                check("out_z", {32'd0, out_z}, {32'd0, q[0].z});
                check("out_store_data", {32'd0, out_store_data}, {32'd0, q[0].sd});
                check("out_rd_we_ctrl", {52'd0, out_rd, out_reg_we, out_ctrl},
                      {52'd0, q[0].rd, q[0].we, q[0].ctrl});
                check("out_flags", {62'd0, out_equal, out_zero}, {62'd0, q[0].eq, q[0].zr});
                if (out_ready) begin
                    void'(q.pop_front());
                end
            end
`ifdef EX_MEM_STALL_CNT_EN
            check("stall_cycles_model", {32'd0, stall_cycles}, {32'd0, exp_stall});
            if (out_valid && !out_ready) begin
                exp_stall = exp_stall + 32'd1;
            end
`endif
        end else begin
`ifdef EX_MEM_STALL_CNT_EN
            exp_stall = '0;
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_out_z", {32'd0, out_z}, 64'd0);
        check("reset_out_reg_we", {63'd0, out_reg_we}, 64'd0);

        // Streaming with out_ready held high
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 32'h10 * i, 5'(i), 1'b1, 1'b1, 1'b0, 1'b0);
            check("stream_out_z", {32'd0, out_z}, {32'd0, 32'h10 * i});
            check("stream_in_ready", {63'd0, in_ready}, 64'd1);
        end
        idle(1'b1);
        check("stream_drained", {63'd0, out_valid}, 64'd0);

        // Backpressure fill, then drain
        step(1'b1, 32'hA, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        check("bp_in_ready_full", {63'd0, in_ready}, 64'd0);
        check("bp_out_z_hold", {32'd0, out_z}, 64'hA);
        step(1'b1, 32'hC, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        check("bp_out_z_stable", {32'd0, out_z}, 64'hA);
        idle(1'b1);
        check("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
        check("bp_second_out_z", {32'd0, out_z}, 64'hB);
        idle(1'b1);
        idle(1'b1);

        // x0 write suppression
        step(1'b1, 32'h100, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("x0_reg_we", {63'd0, out_reg_we}, 64'd0);
        step(1'b1, 32'h104, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        check("x5_reg_we", {63'd0, out_reg_we}, 64'd1);
        check("x5_rd", {59'd0, out_rd}, 64'd5);
        idle(1'b1);

        // Flush while two entries are held
        step(1'b1, 32'h1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h3, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        idle(1'b1);
        idle(1'b1);

        // Flush in ONE drops a simultaneous input even though in_ready=1
        step(1'b1, 32'h21, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h22, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        check("flush_one_out_valid", {63'd0, out_valid}, 64'd0);
        idle(1'b1);

        // Reset mid-operation
        step(1'b1, 32'h77, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_out_z", {32'd0, out_z}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        step(1'b1, 32'h55, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        check("post_rst_out_z", {32'd0, out_z}, 64'h55);
        idle(1'b1);

`ifdef EX_MEM_STALL_CNT_EN
        step(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h99, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            idle(1'b0);
        end
        idle(1'b1);
        check("stall_after_pop", {32'd0, stall_cycles}, 64'd7);
        step(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("stall_after_flush", {32'd0, stall_cycles}, 64'd7);
        step(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("stall_after_rst", {32'd0, stall_cycles}, 64'd0);
        idle(1'b1);
`endif

        check("queue_empty_at_end", {32'd0, 32'(q.size())}, 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
